// File: rtl/eu_xbuf_in_arbiter.sv
`default_nettype none
// =============================================================================
// eu_xbuf_in_arbiter: round-robin sharing of one xbuf write port among NUM_REQ
// producers, with bounded retry and forced backoff.            Rev 1.0
// =============================================================================
module eu_xbuf_in_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int RETRY_LIMIT    = 8,
    parameter int BACKOFF_CYCLES = 2,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [ADDR_W-1:0]              xbuf_in_addr_o,
    output logic [DATA_W-1:0]              xbuf_in_data_o,
    output logic                           xbuf_in_valid_o,
    input  logic                           xbuf_in_success_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           backoff_o
);
    localparam int RW  = $clog2(NUM_REQ);
    localparam int RCW = $clog2(RETRY_LIMIT + 1);
    localparam int BCW = $clog2(BACKOFF_CYCLES + 1);

    localparam logic [RCW-1:0] RETRY_LAST = RCW'(RETRY_LIMIT - 1);
    localparam logic [BCW-1:0] BO_LAST    = BCW'(BACKOFF_CYCLES - 1);
    localparam logic [RW-1:0]  IDX_LAST   = RW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BACKOFF = 2'd2
    } state_t;

    state_t                      state_q;
    logic [RW-1:0]               gidx_q;
    logic [RW-1:0]               ptr_q;
    logic [RCW-1:0]              retry_q;
    logic [BCW-1:0]              bo_q;
    logic                        valid_q;
    logic                        backoff_q;
    logic [NUM_REQ-1:0]          grant_q;
    logic [ADDR_W-1:0]           addr_q;
    logic [DATA_W-1:0]           data_q;

    logic [NUM_REQ-1:0]             slot_full_q;
    logic [NUM_REQ-1:0][ADDR_W-1:0] slot_addr_q;
    logic [NUM_REQ-1:0][DATA_W-1:0] slot_data_q;

    logic                        issue_ok;
    logic                        pick_vld;
    logic [RW-1:0]               pick_idx;
    logic [RW-1:0]               cand;
    logic [RW-1:0]               ptr_d;

    assign issue_ok = (state_q == ST_ISSUE) && xbuf_in_success_i;
    assign ptr_d    = (gidx_q == IDX_LAST) ? '0 : gidx_q + RW'(1);

    // Slot storage: a slot only reloads once it has been observed empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_full_q <= '0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid_i[i] && !slot_full_q[i]) begin
                    slot_full_q[i] <= 1'b1;
                    slot_addr_q[i] <= req_addr_i[i];
                    slot_data_q[i] <= req_data_i[i];
                end else if (issue_ok && (gidx_q == RW'(i))) begin
                    slot_full_q[i] <= 1'b0;
                end
            end
        end
    end

    // First full slot at or above ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k >= NUM_REQ) ? RW'(int'(ptr_q) + k - NUM_REQ)
                                                : RW'(int'(ptr_q) + k);
            if (!pick_vld && slot_full_q[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gidx_q    <= '0;
            ptr_q     <= '0;
            retry_q   <= '0;
            bo_q      <= '0;
            valid_q   <= 1'b0;
            backoff_q <= 1'b0;
            grant_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state_q <= ST_ISSUE;
                        gidx_q  <= pick_idx;
                        valid_q <= 1'b1;
                        grant_q <= NUM_REQ'(1) << pick_idx;
                        addr_q  <= slot_addr_q[pick_idx];
                        data_q  <= slot_data_q[pick_idx];
                    end
                end
                ST_ISSUE: begin
                    if (xbuf_in_success_i) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= ptr_d;
                        retry_q <= '0;
                        valid_q <= 1'b0;
                        grant_q <= '0;
                    end else if (retry_q == RETRY_LAST) begin
                        // Give the port away; the slot stays full and loses priority.
                        state_q   <= ST_BACKOFF;
                        ptr_q     <= ptr_d;
                        retry_q   <= '0;
                        valid_q   <= 1'b0;
                        grant_q   <= '0;
                        backoff_q <= 1'b1;
                    end else begin
                        retry_q <= retry_q + RCW'(1);
                    end
                end
                ST_BACKOFF: begin
                    if (bo_q == BO_LAST) begin
                        state_q   <= ST_IDLE;
                        bo_q      <= '0;
                        backoff_q <= 1'b0;
                    end else begin
                        bo_q <= bo_q + BCW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o     = ~slot_full_q;
    assign xbuf_in_valid_o = valid_q;
    assign xbuf_in_addr_o  = addr_q;
    assign xbuf_in_data_o  = data_q;
    assign grant_o         = grant_q;
    assign backoff_o       = backoff_q;

endmodule
`default_nettype wire

// File: tb/tb_eu_xbuf_in_arbiter.sv
`default_nettype none
// =============================================================================
// tb_eu_xbuf_in_arbiter: vector table plus cycle-exact sequences, with a write
// scoreboard, for eu_xbuf_in_arbiter.                          Rev 1.0
// =============================================================================
module tb_eu_xbuf_in_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]         req_valid;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_data;
    logic [N-1:0]         req_ready;
    logic [AW-1:0]        in_addr;
    logic [DW-1:0]        in_data;
    logic                 in_valid;
    logic                 in_success;
    logic [N-1:0]         grant;
    logic                 backoff;

    logic [2:0]           req_valid3;
    logic [2:0][AW-1:0]   req_addr3;
    logic [2:0][DW-1:0]   req_data3;
    logic [2:0]           req_ready3;
    logic [AW-1:0]        in_addr3;
    logic [DW-1:0]        in_data3;
    logic                 in_valid3;
    logic                 in_success3;
    logic [2:0]           grant3;
    logic                 backoff3;

    eu_xbuf_in_arbiter #(.NUM_REQ(N), .RETRY_LIMIT(8), .BACKOFF_CYCLES(2),
                         .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ready_o(req_ready),
        .xbuf_in_addr_o(in_addr), .xbuf_in_data_o(in_data),
        .xbuf_in_valid_o(in_valid), .xbuf_in_success_i(in_success),
        .grant_o(grant), .backoff_o(backoff)
    );

    eu_xbuf_in_arbiter #(.NUM_REQ(3), .RETRY_LIMIT(8), .BACKOFF_CYCLES(2),
                         .ADDR_W(AW), .DATA_W(DW)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid3), .req_addr_i(req_addr3), .req_data_i(req_data3),
        .req_ready_o(req_ready3),
        .xbuf_in_addr_o(in_addr3), .xbuf_in_data_o(in_data3),
        .xbuf_in_valid_o(in_valid3), .xbuf_in_success_i(in_success3),
        .grant_o(grant3), .backoff_o(backoff3)
    );

    typedef struct packed {
        logic [N-1:0]  g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        logic [N-1:0]    mask;
        int              n;
        logic [3:0][1:0] ord;
    } vec_t;

    vec_t tbl [8];
    wr_t  exp_q [$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   acc_n = 0;
    int   first_acc = 0;
    int   last_acc = 0;
    int   t0 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic wr_t mk(input int s, input int v);
        wr_t w;
        w.g = N'(1) << s;
        w.a = AW'(32'hA000 + v * 16 + s);
        w.d = 32'hD000_0000 + DW'(v * 256 + s);
        return w;
    endfunction

    // Scores a write accepted in the current cycle, then advances one clock.
    task automatic step();
        wr_t e;
        if (in_valid && in_success) begin
            acc_n++;
            if (acc_n == 1) first_acc = cyc;
            last_acc = cyc;
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL sb_extra: unexpected write grant=%b addr=0x%0h, required none", grant, in_addr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_grant", grant, e.g);
                chk("sb_addr", in_addr, e.a);
                chk("sb_data", in_data, e.d);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input logic [N-1:0] mask, input int seed);
        wr_t w;
        for (int i = 0; i < N; i++) begin
            w = mk(i, seed);
            req_addr[i] = w.a;
            req_data[i] = w.d;
        end
        req_valid = mask;
        step();
        req_valid = '0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b1111, 4, 8'b11_10_01_00};
        tbl[1] = '{4'b1111, 4, 8'b11_10_01_00};
        tbl[2] = '{4'b0001, 1, 8'b00_00_00_00};
        tbl[3] = '{4'b0100, 1, 8'b00_00_00_10};
        tbl[4] = '{4'b0010, 1, 8'b00_00_00_01};
        tbl[5] = '{4'b1011, 3, 8'b00_01_00_11};
        tbl[6] = '{4'b0110, 2, 8'b00_00_01_10};
        tbl[7] = '{4'b1101, 3, 8'b00_00_11_10};

        reset       = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        in_success  = 1'b0;
        req_valid3  = '0;
        req_addr3   = '0;
        req_data3   = '0;
        in_success3 = 1'b1;
        step();
        step();
        chk("rst_valid", in_valid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_backoff", backoff, 0);
        chk("rst_ready", req_ready, 4'b1111);
        chk("rst_addr", in_addr, 0);
        chk("rst_data", in_data, 0);
        reset = 1'b0;
        step();

        // Table: loads per mask, success always 1, order checked by the scoreboard.
        in_success = 1'b1;
        for (int v = 0; v < 8; v++) begin
            acc_n = 0;
            t0 = cyc;
            for (int k = 0; k < tbl[v].n; k++) exp_q.push_back(mk(int'(tbl[v].ord[k]), v + 1));
            load(tbl[v].mask, v + 1);
            drain(40);
            chk("vec_count", acc_n, tbl[v].n);
            chk("vec_latency", first_acc - t0, 2);
            chk("vec_spacing", last_acc - first_acc, 2 * (tbl[v].n - 1));
            chk("vec_ready", req_ready, 4'b1111);
        end

        // Reset asserted in the middle of an ISSUE cycle.
        in_success = 1'b0;
        load(4'b0001, 20);
        step();
        chk("mid_valid_pre", in_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_valid", in_valid, 0);
        chk("mid_grant", grant, 0);
        chk("mid_ready", req_ready, 4'b1111);
        step();
        reset = 1'b0;
        step();

        // Single write with cycle-exact ready/valid.
        in_success = 1'b1;
        exp_q.push_back(mk(0, 21));
        load(4'b0001, 21);
        chk("single_ready_t1", req_ready, 4'b1110);
        chk("single_valid_t1", in_valid, 0);
        step();
        chk("single_ready_t2", req_ready, 4'b1110);
        chk("single_valid_t2", in_valid, 1);
        chk("single_grant_t2", grant, 4'b0001);
        step();
        chk("single_ready_t3", req_ready, 4'b1111);
        chk("single_valid_t3", in_valid, 0);
        chk("single_grant_t3", grant, 0);
        chk("single_addr_hold", in_addr, mk(0, 21).a);
        chk("single_sb_empty", exp_q.size(), 0);

        // Retry limit then backoff; ptr=1 so slot 1 goes first, slot 0 after backoff.
        in_success = 1'b0;
        load(4'b0011, 22);
        step();
        for (int k = 0; k < 8; k++) begin
            chk("retry_valid", in_valid, 1);
            chk("retry_grant", grant, 4'b0010);
            chk("retry_backoff", backoff, 0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            chk("bo_valid", in_valid, 0);
            chk("bo_backoff", backoff, 1);
            chk("bo_grant", grant, 0);
            step();
        end
        chk("bo_idle_valid", in_valid, 0);
        chk("bo_idle_backoff", backoff, 0);
        exp_q.push_back(mk(0, 22));
        exp_q.push_back(mk(1, 22));
        in_success = 1'b1;
        step();
        chk("bo_next_grant", grant, 4'b0001);
        drain(20);

        // Success on the final retry: no backoff.
        in_success = 1'b0;
        exp_q.push_back(mk(2, 23));
        load(4'b0100, 23);
        step();
        for (int k = 0; k < 7; k++) begin
            chk("last_valid", in_valid, 1);
            chk("last_backoff", backoff, 0);
            step();
        end
        in_success = 1'b1;
        step();
        chk("last_valid_after", in_valid, 0);
        chk("last_backoff_after", backoff, 0);
        chk("last_ready", req_ready, 4'b1111);
        chk("last_sb_empty", exp_q.size(), 0);
        step();
        chk("last_backoff_later", backoff, 0);

        // NUM_REQ=3: pointer wraps 2 -> 0.
        req_addr3[2] = 16'h3002;
        req_addr3[0] = 16'h3000;
        req_valid3   = 3'b100;
        step();
        req_valid3 = '0;
        step();
        chk("w3_valid", in_valid3, 1);
        chk("w3_grant_a", grant3, 3'b100);
        chk("w3_addr", in_addr3, 16'h3002);
        step();
        step();
        req_valid3 = 3'b101;
        step();
        req_valid3 = '0;
        step();
        chk("w3_grant_wrap", grant3, 3'b001);
        step();
        step();
        chk("w3_grant_b", grant3, 3'b100);
        step();
        step();
        chk("w3_ready", req_ready3, 3'b111);
        chk("w3_backoff", backoff3, 0);
        chk("w3_data", in_data3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
`default_nettype wire
